qa_drv_write_fence: RTL
=======================

QA_DRV_WRITE_FENCE -- requirements
Module: qa_drv_write_fence

Interface
REQ-001 SHALL have parameter CCI_ADDR_WIDTH, default 56: write address width.
REQ-002 SHALL have parameter CCI_DATA_WIDTH, default 512: write data width (one cache line).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 64: cap on unacknowledged writes; CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 reset  in  1  synchronous reset, active high.
REQ-007 wr_addr  in  CCI_ADDR_WIDTH  client write address.
REQ-008 wr_data  in  CCI_DATA_WIDTH  client write data.
REQ-009 wr_cached  in  1  client cache hint.
REQ-010 wr_check_order  in  1  client same-line ordering request.
REQ-011 wr_rdy  out  1  block can accept a write this cycle.
REQ-012 wr_enable  in  1  client write strobe; legal only when wr_rdy=1.
REQ-013 fence_enable  in  1  client fence request strobe; legal only when fence_rdy=1.
REQ-014 fence_rdy  out  1  block can accept a fence this cycle.
REQ-015 fence_done  out  1  one-cycle pulse: all writes accepted before the fence are acknowledged.
REQ-016 mem_write_addr / mem_write_data / mem_write_req_cached / mem_write_req_check_order  out  CCI_ADDR_WIDTH/CCI_DATA_WIDTH/1/1  to driver write port.
REQ-017 mem_write_rdy  in  1  driver write port ready.
REQ-018 mem_write_enable  out  1  driver write strobe.
REQ-019 mem_write_ack  in  2  count of writes completed this cycle (0..3).
REQ-020 outstanding  out  CNT_W  writes issued to driver and not yet acked.
REQ-021 ack_underflow  out  1  sticky error: ack count exceeded outstanding.

Function
REQ-022 SHALL hold one write-buffer entry (buf_valid plus addr/data/cached/check_order) registered between client and driver.
REQ-023 SHALL assert mem_write_enable = buf_valid && mem_write_rdy, with mem_write_* fields driven from the buffer.
REQ-024 SHALL assert wr_rdy = (state==RUN) && (!buf_valid || mem_write_rdy) && (outstanding + buf_valid < MAX_OUTSTANDING).
REQ-025 SHALL load the buffer on wr_enable; a buffer drained and refilled in the same cycle holds the new write, with no bubble.
REQ-026 SHALL update outstanding_next = outstanding + mem_write_enable - mem_write_ack, with issue and ack in the same cycle both applied.
REQ-027 SHALL, when mem_write_ack exceeds outstanding + mem_write_enable, saturate outstanding at 0 and set ack_underflow until reset.
REQ-028 SHALL implement states RUN, DRAIN and DONE.
REQ-029 RUN: fence_rdy=1; on fence_enable, go to DRAIN.
REQ-030 DRAIN: fence_rdy=0 and wr_rdy=0; go to DONE when buf_valid=0 and registered outstanding==0.
REQ-031 DONE: fence_done=1 for exactly one cycle, fence_rdy=0, wr_rdy=0; go to RUN.
REQ-032 SHALL, when wr_enable and fence_enable fire in the same RUN cycle, order the write before the fence, so the fence waits for its ack.
REQ-033 SHALL have a minimum fence latency with nothing outstanding of: fence_enable in cycle N gives fence_done in cycle N+2.
REQ-034 SHALL keep mem_write_* fields stable while buf_valid=1 and mem_write_rdy=0.

Reset
REQ-035 SHALL, on reset, set state=RUN, buf_valid=0, outstanding=0, ack_underflow=0, mem_write_enable=0 and fence_done=0; wr_rdy and fence_rdy are 1 in the first cycle after reset.
REQ-036 SHALL, on reset during DRAIN or DONE, abandon the fence and not emit fence_done; acks arriving after reset count toward underflow.

Verification
REQ-037 Single write, mem_write_rdy=1, ack=1 three cycles later: mem_write_enable high 1 cycle after wr_enable; outstanding goes 0->1->0.
REQ-038 Fence with outstanding=0: fence_enable in cycle 10 gives fence_done in cycle 12 only; wr_rdy=0 in cycles 11-12.
REQ-039 Four writes, then fence, acks returned as 2,0,1,1: fence_done fires in the cycle after outstanding reaches 0, never earlier.
REQ-040 MAX_OUTSTANDING=4 with no acks: wr_rdy drops after 4 writes; ack=1 re-raises wr_rdy the next cycle.
REQ-041 Same cycle issue=1 and ack=2 with outstanding=1: outstanding=0 and ack_underflow=0; ack=1 with outstanding=0 sets ack_underflow=1.
REQ-042 mem_write_rdy held low for 5 cycles with buffer full: buffer fields unchanged, wr_rdy=0; write issues on the first ready cycle.

Source files
------------

// File: rtl/qa_drv_write_fence.sv
// ============================================================================
// Module      : qa_drv_write_fence
// Description : Single-entry write buffer to the driver write port with
//               outstanding-write tracking and a write fence (RUN/DRAIN/DONE).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qa_drv_write_fence #(
    parameter int CCI_ADDR_WIDTH  = 56,
    parameter int CCI_DATA_WIDTH  = 512,
    parameter int MAX_OUTSTANDING = 64,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CCI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [CCI_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_cached,
    input  logic                      wr_check_order,
    output logic                      wr_rdy,
    input  logic                      wr_enable,
    input  logic                      fence_enable,
    output logic                      fence_rdy,
    output logic                      fence_done,
    output logic [CCI_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [CCI_DATA_WIDTH-1:0] mem_write_data,
    output logic                      mem_write_req_cached,
    output logic                      mem_write_req_check_order,
    input  logic                      mem_write_rdy,
    output logic                      mem_write_enable,
    input  logic [1:0]                mem_write_ack,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      ack_underflow
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W:0] c_max_out = (CNT_W + 1)'(MAX_OUTSTANDING);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_run;

    logic                      r_buf_valid;
    logic [CCI_ADDR_WIDTH-1:0] r_buf_addr;
    logic [CCI_DATA_WIDTH-1:0] r_buf_data;
    logic                      r_buf_cached;
    logic                      r_buf_order;

    logic [CNT_W-1:0]          r_outstanding;
    logic                      r_ack_underflow;
    logic [CNT_W:0]            w_issue_sum;
    logic [CNT_W:0]            w_occupancy;
    logic                      w_underflow;
    logic [CNT_W-1:0]          w_out_next;

    assign mem_write_enable          = r_buf_valid && mem_write_rdy;
    assign mem_write_addr            = r_buf_addr;
    assign mem_write_data            = r_buf_data;
    assign mem_write_req_cached      = r_buf_cached;
    assign mem_write_req_check_order = r_buf_order;

    assign outstanding   = r_outstanding;
    assign ack_underflow = r_ack_underflow;

    // Occupancy counts the buffered write so the cap holds once it issues.
    assign w_occupancy = {1'b0, r_outstanding} + {{CNT_W{1'b0}}, r_buf_valid};
    assign wr_rdy      = w_run && (!r_buf_valid || mem_write_rdy) && (w_occupancy < c_max_out);

    assign w_issue_sum = {1'b0, r_outstanding} + {{CNT_W{1'b0}}, mem_write_enable};
    assign w_underflow = (CNT_W + 1)'(mem_write_ack) > w_issue_sum;
    assign w_out_next  = w_underflow ? '0
                       : r_outstanding + CNT_W'(mem_write_enable) - CNT_W'(mem_write_ack);

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        fence_rdy    = 1'b0;
        fence_done   = 1'b0;
        case (r_state)
            S_RUN: begin
                w_run     = 1'b1;
                fence_rdy = 1'b1;
                if (fence_enable) w_state_next = S_DRAIN;
            end
            // Registered outstanding is used, so done lands one cycle after it hits zero.
            S_DRAIN: begin
                if (!r_buf_valid && (r_outstanding == '0)) w_state_next = S_DONE;
            end
            S_DONE: begin
                fence_done   = 1'b1;
                w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_RUN;
            r_buf_valid     <= 1'b0;
            r_outstanding   <= '0;
            r_ack_underflow <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            if (w_underflow) r_ack_underflow <= 1'b1;
            if (wr_enable)             r_buf_valid <= 1'b1;
            else if (mem_write_enable) r_buf_valid <= 1'b0;
        end
    end

    // Payload only changes on a load, which keeps it stable while stalled.
    always_ff @(posedge clk) begin
        if (wr_enable) begin
            r_buf_addr   <= wr_addr;
            r_buf_data   <= wr_data;
            r_buf_cached <= wr_cached;
            r_buf_order  <= wr_check_order;
        end
    end

endmodule

`default_nettype wire
